// File: rtl/gen_direcciones_imagen.sv
// Raster-order address sequencer: walks an ancho x alto image of 32-bit words and
// emits base + 4*index with its row/column through a valid/ready handshake.
module gen_direcciones_imagen #(
  parameter int DIM_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base,
  input  logic [DIM_W-1:0] ancho,
  input  logic [DIM_W-1:0] alto,
  output logic [31:0]      dir,
  output logic             dir_valid,
  input  logic             dir_ready,
  output logic [DIM_W-1:0] fila,
  output logic [DIM_W-1:0] col,
  output logic             ocupado,
  output logic             fin
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [DIM_W-1:0] DIM_UNO = DIM_W'(1);

  state_t           state_q, state_d;
  logic [29:0]      base_q, base_d;
  logic [DIM_W-1:0] ancho_q, ancho_d, alto_q, alto_d;
  logic [DIM_W-1:0] fila_q, fila_d, col_q, col_d;
  logic [31:0]      idx_q, idx_d, dir_q, dir_d;
  logic             valid_q, valid_d, fin_q, fin_d, ocup_q, ocup_d;
  logic             handshake, ultima_col, ultima_fila;
  logic             unused_base_lsb;

  // Word-aligned addressing: the two low address bits never reach the datapath.
  assign unused_base_lsb = ^base[1:0];

  assign handshake   = valid_q & dir_ready;
  assign ultima_col  = (col_q == ancho_q - DIM_UNO);
  assign ultima_fila = (fila_q == alto_q - DIM_UNO);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    ancho_d = ancho_q;
    alto_d  = alto_q;
    fila_d  = fila_q;
    col_d   = col_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ancho != '0 && alto != '0) begin
            base_d  = base[31:2];
            ancho_d = ancho;
            alto_d  = alto;
            fila_d  = '0;
            col_d   = '0;
            idx_d   = '0;
            dir_d   = {base[31:2], 2'b00};
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (handshake) begin
          idx_d = idx_q + 32'd1;
          // Next address precomputed here so dir is a plain register output.
          dir_d = {base_q, 2'b00} + (idx_d << 2);
          if (ultima_col) begin
            col_d = '0;
            if (ultima_fila) state_d = DONE;
            else             fila_d  = fila_q + DIM_UNO;
          end else begin
            col_d = col_q + DIM_UNO;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == RUN);
    fin_d   = (state_d == DONE);
    ocup_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      ancho_q <= '0;
      alto_q  <= '0;
      fila_q  <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      dir_q   <= '0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      ancho_q <= ancho_d;
      alto_q  <= alto_d;
      fila_q  <= fila_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
      ocup_q  <= ocup_d;
    end
  end

  assign dir       = dir_q;
  assign dir_valid = valid_q;
  assign fila      = fila_q;
  assign col       = col_q;
  assign ocupado   = ocup_q;
  assign fin       = fin_q;

endmodule

// File: tb/tb_gen_direcciones_imagen.sv
// Randomized and directed scans checked against a raster-order address model.
module tb_gen_direcciones_imagen;

  localparam int DIM_W = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base = '0;
  logic [DIM_W-1:0] ancho = '0;
  logic [DIM_W-1:0] alto = '0;
  logic             dir_ready = 1'b0;
  logic [31:0]      dir;
  logic             dir_valid;
  logic [DIM_W-1:0] fila;
  logic [DIM_W-1:0] col;
  logic             ocupado;
  logic             fin;

  int checks = 0;
  int errors = 0;

  gen_direcciones_imagen #(.DIM_W(DIM_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base),
    .ancho(ancho), .alto(alto), .dir(dir), .dir_valid(dir_valid),
    .dir_ready(dir_ready), .fila(fila), .col(col),
    .ocupado(ocupado), .fin(fin)
  );

  always #5 clk = ~clk;

  // Must be entered right after a falling edge with the DUT idle.
  // mode 0: ready always high; 1: random ready; 2: 3-cycle stall on third
  // address; 3: ready high plus a start pulse with other parameters mid-scan.
  task automatic run_scan(input logic [31:0] b, input int w, input int h,
                          input int mode, input string name);
    logic [31:0] exp_a[$];
    int          exp_f[$];
    int          exp_c[$];
    logic [31:0] aligned;
    int total, n, cyc, last_hs, stalls, budget;
    bit got_fin, r;
    aligned = {b[31:2], 2'b00};
    for (int fr = 0; fr < h; fr++)
      for (int cc = 0; cc < w; cc++) begin
        exp_a.push_back(aligned + 32'((fr * w + cc) * 4));
        exp_f.push_back(fr);
        exp_c.push_back(cc);
      end
    total = w * h;
    budget = total * 20 + 20;
    n = 0; cyc = 0; last_hs = -1; stalls = 0; got_fin = 0;
    base = b; ancho = DIM_W'(w); alto = DIM_W'(h);
    dir_ready = (mode != 1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!got_fin && cyc < budget) begin
      if (fin) begin
        got_fin = 1;
        checks++;
        if (n != total || cyc != last_hs + 1 || dir_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s fin: got handshakes=%0d fin_cycle=%0d valid=%b, expected handshakes=%0d fin_cycle=%0d valid=0",
                   name, n, cyc, dir_valid, total, last_hs + 1);
        end
      end else begin
        if (dir_valid === 1'b1) begin
          checks++;
          if (n >= total) begin
            errors++;
            $display("FAIL %s extra_addr: got %h beyond %0d addresses", name, dir, total);
          end else if (dir !== exp_a[n] || fila !== DIM_W'(exp_f[n]) || col !== DIM_W'(exp_c[n])) begin
            errors++;
            $display("FAIL %s addr[%0d]: got %h (%0d,%0d) expected %h (%0d,%0d)",
                     name, n, dir, fila, col, exp_a[n], exp_f[n], exp_c[n]);
          end
        end else begin
          checks++;
          if (n < total) begin
            errors++;
            $display("FAIL %s valid: got dir_valid=%b at cycle %0d expected 1 (%0d of %0d sent)",
                     name, dir_valid, cyc, n, total);
          end
        end
        case (mode)
          1: r = 1'($urandom_range(0, 1));
          2: if (n == 2 && stalls < 3) begin r = 0; stalls++; end else r = 1;
          default: r = 1;
        endcase
        if (mode == 3 && cyc == 1) begin
          start = 1'b1; base = ~b; ancho = DIM_W'(w + 1); alto = DIM_W'(h + 2);
        end
        if (mode == 3 && cyc == 2) start = 1'b0;
        dir_ready = r;
        if (dir_valid === 1'b1 && r) begin
          n++;
          last_hs = cyc;
        end
        cyc++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    checks++;
    if (!got_fin) begin
      errors++;
      $display("FAIL %s timeout: got no fin after %0d cycles, expected fin", name, cyc);
    end else begin
      checks++;
      if (ocupado !== 1'b1) begin
        errors++;
        $display("FAIL %s ocupado_fin: got %b expected 1", name, ocupado);
      end
      @(negedge clk);
      checks++;
      if (ocupado !== 1'b0 || fin !== 1'b0 || dir_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s idle_after: got ocupado=%b fin=%b valid=%b expected 0 0 0",
                 name, ocupado, fin, dir_valid);
      end
    end
    $display("scan %s base=%h %0dx%0d handshakes=%0d cycles=%0d", name, b, w, h, n, cyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dir !== 32'h0 || dir_valid !== 1'b0 || fila !== '0 || col !== '0 ||
        ocupado !== 1'b0 || fin !== 1'b0) begin
      errors++;
      $display("FAIL reset: got dir=%h valid=%b fila=%0d col=%0d ocupado=%b fin=%b expected all 0",
               dir, dir_valid, fila, col, ocupado, fin);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset outputs checked");
  endtask

  task automatic test_basic();
    run_scan(32'h0000_1000, 4, 2, 0, "basic");
  endtask

  task automatic test_backpressure();
    run_scan(32'h0000_1000, 4, 2, 2, "backpressure");
  endtask

  task automatic test_zero_and_unaligned();
    run_scan(32'h0000_1000, 0, 5, 0, "zero_ancho");
    run_scan(32'h0000_1000, 3, 0, 0, "zero_alto");
    run_scan(32'h0000_1003, 1, 1, 0, "unaligned");
  endtask

  task automatic test_wrap_and_ignored_start();
    run_scan(32'hFFFF_FFF8, 4, 1, 3, "wrap_ignored_start");
  endtask

  task automatic test_reset_mid();
    bit seen_fin;
    seen_fin = 0;
    base = 32'h0000_2000; ancho = DIM_W'(4); alto = DIM_W'(4);
    dir_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dir !== 32'h0000_200C) begin
      errors++;
      $display("FAIL reset_mid pre: got dir=%h expected 0000200c", dir);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dir !== 32'h0 || dir_valid !== 1'b0 || fila !== '0 || col !== '0 ||
        ocupado !== 1'b0 || fin !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid async: got dir=%h valid=%b fila=%0d col=%0d ocupado=%b fin=%b expected all 0",
               dir, dir_valid, fila, col, ocupado, fin);
    end
    repeat (3) begin
      @(negedge clk);
      if (fin !== 1'b0) seen_fin = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (fin !== 1'b0 || ocupado !== 1'b0) seen_fin = 1;
    end
    checks++;
    if (seen_fin) begin
      errors++;
      $display("FAIL reset_mid no_fin: got fin/ocupado activity after abort, expected none");
    end
    $display("reset mid-scan abort checked");
    run_scan(32'h0000_2000, 4, 4, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_scan(32'h0000_3000, 2, 2, 0, "b2b_first");
    run_scan(32'h0000_4004, 3, 1, 0, "b2b_second");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_scan($urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), 1,
               $sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_and_unaligned();
    test_wrap_and_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
